// File: rtl/l2_arb_pkg.sv
// Shared types and constants for the L2 request arbiter: source encoding,
// FSM states and the queued request record at the default address width.
package l2_arb_pkg;

    localparam int DEFAULT_ADDR_W = 26;
    localparam int DEFAULT_DEPTH  = 4;

    localparam logic SRC_INSTR = 1'b0;
    localparam logic SRC_DATA  = 1'b1;

    typedef enum logic {
        ARB_IDLE,
        ARB_ISSUE
    } arb_state_t;

    typedef struct packed {
        logic [DEFAULT_ADDR_W-1:0] addr;
        logic                      write;
    } l2_req_t;

endpackage

// File: rtl/l2_request_arbiter_req_fifo.sv
// Per-requester request queue (module req_fifo): DEPTH entries, registered
// full/empty flags, so a full queue refuses a push even while it is being popped.
module req_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 27
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic             push_ok;
    logic             pop_ok;

    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr];

    // NOTE: combinational blocks use '=' and assign every output a default
    // first so no latch is inferred; clocked state below uses '<=' only.
    always_comb begin
        count_next = count;
        if (push_ok && !pop_ok) begin
            count_next = count + CNT_W'(1);
        end else if (!push_ok && pop_ok) begin
            count_next = count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count_next;
            full  <= (count_next == CNT_W'(DEPTH));
            empty <= (count_next == '0);
        end
    end

    // NOTE: storage has no reset; the pointers and count define validity, and
    // leaving the array unreset lets it map onto plain flops or RAM.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/l2_request_arbiter.sv
// Round-robin arbiter sharing the L2 request port between the L1 I- and D-caches.
// Optional statistics counters are built when ARB_STATS_EN is defined.
module l2_request_arbiter
    import l2_arb_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int DEPTH  = DEFAULT_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_valid,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ready,
    input  logic              d_valid,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic              d_write,
    output logic              d_ready,
    output logic              l2_valid,
    output logic [ADDR_W-1:0] l2_addr,
    output logic              l2_write,
    output logic              l2_src,
    input  logic              l2_ready,
    output logic              busy
`ifdef ARB_STATS_EN
    ,
    output logic [31:0]       i_grants,
    output logic [31:0]       d_grants,
    output logic [31:0]       stall_cycles
`endif
);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              write;
    } req_t;

    localparam int REQ_W = $bits(req_t);

    req_t       i_push_req;
    req_t       d_push_req;
    req_t       i_head;
    req_t       d_head;
    logic       i_full;
    logic       i_empty;
    logic       d_full;
    logic       d_empty;
    logic       pop_i;
    logic       pop_d;
    logic       load;
    logic       win_src;
    logic       last_src;
    arb_state_t state;
    arb_state_t state_next;

    // Instruction fetches never write, so the queued write bit is tied low.
    assign i_push_req = '{addr: i_addr, write: 1'b0};
    assign d_push_req = '{addr: d_addr, write: d_write};

    req_fifo #(.DEPTH(DEPTH), .WIDTH(REQ_W)) u_i_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (i_valid),
        .push_data (i_push_req),
        .full      (i_full),
        .pop       (pop_i),
        .head      (i_head),
        .empty     (i_empty)
    );

    req_fifo #(.DEPTH(DEPTH), .WIDTH(REQ_W)) u_d_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (d_valid),
        .push_data (d_push_req),
        .full      (d_full),
        .pop       (pop_d),
        .head      (d_head),
        .empty     (d_empty)
    );

    assign i_ready  = !i_full;
    assign d_ready  = !d_full;
    assign l2_valid = (state == ARB_ISSUE);
    assign busy     = !i_empty || !d_empty || l2_valid;

    always_comb begin
        state_next = state;
        load       = 1'b0;
        win_src    = SRC_INSTR;

        // On contention the source that lost the previous grant goes next.
        if (i_empty && !d_empty) begin
            win_src = SRC_DATA;
        end else if (!i_empty && !d_empty) begin
            win_src = (last_src == SRC_DATA) ? SRC_INSTR : SRC_DATA;
        end

        case (state)
            ARB_IDLE: begin
                if (!i_empty || !d_empty) begin
                    load       = 1'b1;
                    state_next = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                if (l2_ready) begin
                    if (!i_empty || !d_empty) begin
                        load = 1'b1;
                    end else begin
                        state_next = ARB_IDLE;
                    end
                end
            end
            default: state_next = ARB_IDLE;
        endcase

        pop_i = load && (win_src == SRC_INSTR);
        pop_d = load && (win_src == SRC_DATA);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ARB_IDLE;
            last_src <= SRC_DATA;
            l2_addr  <= '0;
            l2_write <= 1'b0;
            l2_src   <= SRC_INSTR;
        end else begin
            state <= state_next;
            if (load) begin
                l2_addr  <= (win_src == SRC_DATA) ? d_head.addr  : i_head.addr;
                l2_write <= (win_src == SRC_DATA) ? d_head.write : i_head.write;
                l2_src   <= win_src;
                last_src <= win_src;
            end
        end
    end

`ifdef ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_grants     <= '0;
            d_grants     <= '0;
            stall_cycles <= '0;
        end else begin
            if (l2_valid && l2_ready && (l2_src == SRC_INSTR)) begin
                i_grants <= i_grants + 32'd1;
            end
            if (l2_valid && l2_ready && (l2_src == SRC_DATA)) begin
                d_grants <= d_grants + 32'd1;
            end
            if (l2_valid && !l2_ready) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
        end
    end
`endif

endmodule
